// File: rtl/fft_peak_detector_if.sv
// fft_peak_detector_if: FFT source_* stream into the peak detector plus its peak result outputs.
// PEAK_NEIGHBOURS_EN adds the peak_mag_prev/peak_mag_next result signals.
interface fft_peak_detector_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 13
);
    logic                     source_valid;
    logic                     source_ready;
    logic                     source_sop;
    logic                     source_eop;
    logic signed [DATA_W-1:0] source_real;
    logic signed [DATA_W-1:0] source_imag;
    logic                     peak_valid;
    logic [IDX_W-1:0]         peak_bin;
    logic [2*DATA_W-1:0]      peak_mag;
    logic                     frame_err;
`ifdef PEAK_NEIGHBOURS_EN
    logic [2*DATA_W-1:0]      peak_mag_prev;
    logic [2*DATA_W-1:0]      peak_mag_next;
    modport master (
        output source_valid, source_sop, source_eop, source_real, source_imag,
        input  source_ready, peak_valid, peak_bin, peak_mag, frame_err, peak_mag_prev, peak_mag_next
    );
    modport slave (
        input  source_valid, source_sop, source_eop, source_real, source_imag,
        output source_ready, peak_valid, peak_bin, peak_mag, frame_err, peak_mag_prev, peak_mag_next
    );
`else
    modport master (
        output source_valid, source_sop, source_eop, source_real, source_imag,
        input  source_ready, peak_valid, peak_bin, peak_mag, frame_err
    );
    modport slave (
        input  source_valid, source_sop, source_eop, source_real, source_imag,
        output source_ready, peak_valid, peak_bin, peak_mag, frame_err
    );
`endif
endinterface

// File: rtl/fft_peak_detector.sv
// fft_peak_detector: finds the largest |X|^2 bin inside [MIN_BIN,MAX_BIN] of each FFT output frame.
// PEAK_NEIGHBOURS_EN also reports the magnitudes of the bins either side of the peak.
module fft_peak_detector #(
    parameter int DATA_W   = 16,
    parameter int N_POINTS = 8192,
    parameter int IDX_W    = 13,
    parameter int MIN_BIN  = 1,
    parameter int MAX_BIN  = 4095
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    fft_peak_detector_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] MIN_IDX = IDX_W'(MIN_BIN);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_BIN);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t                     r_state, w_next;
    logic                       r_ready, r_drain;
    logic [IDX_W-1:0]           r_bin, w_idx;
    logic                       w_beat, w_take, w_last, w_good_eop, w_err;
    logic signed [2*DATA_W-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
    logic [2*DATA_W-1:0]        w_mag;
    logic                       r_s1_v, r_s1_sop, r_s1_last, r_s1_win;
    logic [2*DATA_W-1:0]        r_s1_mag;
    logic [IDX_W-1:0]           r_s1_bin;
    logic [2*DATA_W-1:0]        r_best_mag, w_base_mag;
    logic [IDX_W-1:0]           r_best_bin, w_base_bin;
    logic                       w_better, r_s2_done;
    logic                       r_pk_valid, r_ferr;
    logic [IDX_W-1:0]           r_pk_bin;
    logic [2*DATA_W-1:0]        r_pk_mag;

    assign w_beat     = bus.source_valid & r_ready;
    assign w_take     = w_beat & ((r_state == COLLECT) | bus.source_sop);
    assign w_idx      = bus.source_sop ? '0 : r_bin;
    assign w_last     = w_idx == LAST;
    assign w_good_eop = bus.source_eop & w_last;
    assign w_err      = w_take & ((bus.source_sop & (r_state == COLLECT)) | (bus.source_eop ^ w_last));

    always_comb begin
        w_next = r_state;
        if (r_state == DRAIN)
            w_next = r_drain ? IDLE : DRAIN;
        else if (w_take)
            w_next = w_good_eop ? DRAIN : (bus.source_eop | w_last) ? IDLE : COLLECT;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_drain <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= w_next != DRAIN;
            r_drain <= (r_state == DRAIN) & ~r_drain;
            if (w_take)
                r_bin <= w_idx + IDX_W'(1);
        end
    end

    // Signed squares are non-negative, so their sum fits unsigned in 2*DATA_W bits.
    assign w_re_ext = {{DATA_W{bus.source_real[DATA_W-1]}}, bus.source_real};
    assign w_im_ext = {{DATA_W{bus.source_imag[DATA_W-1]}}, bus.source_imag};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_mag    = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_s1_v    <= 1'b0;
            r_s1_sop  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_win  <= 1'b0;
            r_s1_mag  <= '0;
            r_s1_bin  <= '0;
        end else begin
            r_s1_v    <= w_take;
            r_s1_sop  <= bus.source_sop;
            r_s1_last <= w_good_eop;
            r_s1_win  <= (w_idx >= MIN_IDX) && (w_idx <= MAX_IDX);
            r_s1_mag  <= w_mag;
            r_s1_bin  <= w_idx;
        end
    end

    // A sop beat restarts the search from the empty result (MIN_BIN, 0).
    assign w_base_mag = r_s1_sop ? '0 : r_best_mag;
    assign w_base_bin = r_s1_sop ? MIN_IDX : r_best_bin;
    assign w_better   = r_s1_win & (r_s1_mag > w_base_mag);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_best_mag <= '0;
            r_best_bin <= MIN_IDX;
            r_s2_done  <= 1'b0;
            r_pk_valid <= 1'b0;
            r_pk_bin   <= '0;
            r_pk_mag   <= '0;
            r_ferr     <= 1'b0;
        end else begin
            if (r_s1_v) begin
                r_best_mag <= w_better ? r_s1_mag : w_base_mag;
                r_best_bin <= w_better ? r_s1_bin : w_base_bin;
            end
            r_s2_done  <= r_s1_v & r_s1_last;
            r_pk_valid <= r_s2_done;
            if (r_s2_done) begin
                r_pk_bin <= r_best_bin;
                r_pk_mag <= r_best_mag;
            end
            r_ferr <= w_err;
        end
    end

`ifdef PEAK_NEIGHBOURS_EN
    logic [2*DATA_W-1:0] r_prev_mag, r_best_prev, r_best_next, r_pk_prev, r_pk_next;
    logic                r_need_next, w_anchor;

    // MIN_BIN anchors the neighbours when it stands as the default (all-zero) result.
    assign w_anchor = w_better | (r_s1_bin == MIN_IDX);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_prev_mag  <= '0;
            r_best_prev <= '0;
            r_best_next <= '0;
            r_need_next <= 1'b0;
            r_pk_prev   <= '0;
            r_pk_next   <= '0;
        end else begin
            if (r_s1_v) begin
                r_prev_mag <= r_s1_mag;
                if (w_anchor) begin
                    r_best_prev <= (r_s1_bin == '0) ? '0 : r_prev_mag;
                    r_best_next <= '0;
                    r_need_next <= 1'b1;
                end else if (r_s1_sop) begin
                    r_best_prev <= '0;
                    r_best_next <= '0;
                    r_need_next <= 1'b0;
                end else if (r_need_next) begin
                    r_best_next <= r_s1_mag;
                    r_need_next <= 1'b0;
                end
            end
            if (r_s2_done) begin
                r_pk_prev <= r_best_prev;
                r_pk_next <= r_best_next;
            end
        end
    end

    assign bus.peak_mag_prev = r_pk_prev;
    assign bus.peak_mag_next = r_pk_next;
`endif

    assign bus.source_ready = r_ready;
    assign bus.peak_valid   = r_pk_valid;
    assign bus.peak_bin     = r_pk_bin;
    assign bus.peak_mag     = r_pk_mag;
    assign bus.frame_err    = r_ferr;
endmodule
